// File: rtl/cbus_arbiter_rr_pkg.sv
// rtl/cbus_arbiter_rr_pkg.sv - shared cache-bus types and arbiter policy enum
package cbus_arbiter_rr_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } cbus_arb_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } cbus_arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    // Grant index width; a single channel still carries a 1-bit id.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// rtl/cbus_arbiter_rr_pick.sv - combinational rotating-base priority picker
module cbus_arbiter_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] index
);

    logic [N-1:0] rot;
    int           slot;

    // Rotate so that bit 0 is the channel at base; lowest set bit of rot wins.
    assign rot = N'({valid, valid} >> base);

    always_comb begin
        found = 1'b0;
        index = '0;
        slot  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                slot  = int'(base) + k;
                if (slot >= N) begin
                    slot = slot - N;
                end
                index = W'(slot);
            end
        end
    end

endmodule

// File: rtl/cbus_arbiter_rr.sv
// rtl/cbus_arbiter_rr.sv - N-channel cache-bus arbiter with fixed or round-robin policy
module cbus_arbiter_rr
    import cbus_arbiter_rr_pkg::*;
#(
    parameter int             NUM_CH   = 2,
    parameter cbus_arb_mode_t ARB_MODE = ARB_FIXED,
    parameter int             CNT_W    = 32,
    localparam int            GID_W    = gid_width(NUM_CH)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_CH],
    output cbus_resp_t       iresps [NUM_CH],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [GID_W-1:0] grant_id,
    output logic [CNT_W-1:0] txn_count
);

    cbus_arb_state_t  state_q;
    cbus_arb_state_t  state_d;
    logic [NUM_CH-1:0] valid_vec;
    logic [GID_W-1:0] rr_ptr;
    logic [GID_W-1:0] pick_base;
    logic [GID_W-1:0] pick_idx;
    logic [GID_W-1:0] next_ptr;
    logic             pick_found;
    logic             done;

    always_comb begin
        valid_vec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    assign pick_base = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    cbus_arbiter_rr_pick #(
        .N (NUM_CH),
        .W (GID_W)
    ) u_pick (
        .valid (valid_vec),
        .base  (pick_base),
        .found (pick_found),
        .index (pick_idx)
    );

    assign done     = (state_q == ST_BUSY) && oresp.ready && oresp.last;
    assign next_ptr = (grant_id == GID_W'(NUM_CH - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pick_found) state_d = ST_BUSY;
            ST_BUSY: if (done)       state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Grant is latched only from IDLE, so it cannot move mid-burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id  <= '0;
            rr_ptr    <= '0;
            txn_count <= '0;
        end else begin
            if (state_q == ST_IDLE && pick_found) begin
                grant_id <= pick_idx;
            end
            if (done) begin
                txn_count <= txn_count + 1'b1;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr <= next_ptr;
                end
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_BUSY);
        oreq = '0;
        if (busy) begin
            oreq = ireqs[grant_id];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            iresps[i] = (busy && grant_id == GID_W'(i)) ? oresp : '0;
        end
    end

    // A granted master must hold valid until it has seen ready && last.
    granted_valid_held: assert property (
        @(posedge clk) disable iff (!reset) (state_q == ST_BUSY) |-> oreq.valid
    );

endmodule

// File: tb/tb_cbus_arbiter_rr.sv
// tb/tb_cbus_arbiter_rr.sv - randomized self-checking bench for cbus_arbiter_rr
module tb_cbus_arbiter_rr;
    import cbus_arbiter_rr_pkg::*;

    localparam int ND      = 3;
    localparam int MAXC    = 4;
    localparam int NCYC    = 2000;
    localparam int RST_CYC = 900;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cbus_req_t  ireq0 [4];
    cbus_req_t  ireq1 [3];
    cbus_req_t  ireq2 [1];
    cbus_resp_t iresp0 [4];
    cbus_resp_t iresp1 [3];
    cbus_resp_t iresp2 [1];
    cbus_req_t  oreq0, oreq1, oreq2;
    cbus_resp_t oresp0, oresp1, oresp2;
    logic       busy0, busy1, busy2;
    logic [1:0] gid0, gid1;
    logic [0:0] gid2;
    logic [3:0] cnt0;
    logic [7:0] cnt1;
    logic [3:0] cnt2;

    cbus_arbiter_rr #(.NUM_CH(4), .ARB_MODE(ARB_RR), .CNT_W(4)) u_rr4 (
        .clk(clk), .reset(reset), .ireqs(ireq0), .iresps(iresp0), .oreq(oreq0),
        .oresp(oresp0), .busy(busy0), .grant_id(gid0), .txn_count(cnt0)
    );
    cbus_arbiter_rr #(.NUM_CH(3), .ARB_MODE(ARB_FIXED), .CNT_W(8)) u_fx3 (
        .clk(clk), .reset(reset), .ireqs(ireq1), .iresps(iresp1), .oreq(oreq1),
        .oresp(oresp1), .busy(busy1), .grant_id(gid1), .txn_count(cnt1)
    );
    cbus_arbiter_rr #(.NUM_CH(1), .ARB_MODE(ARB_RR), .CNT_W(4)) u_one (
        .clk(clk), .reset(reset), .ireqs(ireq2), .iresps(iresp2), .oreq(oreq2),
        .oresp(oresp2), .busy(busy2), .grant_id(gid2), .txn_count(cnt2)
    );

    int nch   [ND] = '{4, 3, 1};
    bit rr    [ND] = '{1'b1, 1'b0, 1'b1};
    int cmask [ND] = '{15, 255, 15};

    bit          rv    [ND][MAXC];
    int          rlen  [ND][MAXC];
    logic [31:0] raddr [ND][MAXC];
    logic [63:0] rdat  [ND][MAXC];
    bit          rwr   [ND][MAXC];

    bit         m_busy [ND];
    int         m_gid  [ND];
    int         m_ptr  [ND];
    int         m_cnt  [ND];
    int         m_beat [ND];
    int         drop   [ND];
    cbus_resp_t mresp  [ND];

    logic       a_busy;
    int         a_gid;
    int         a_cnt;
    cbus_req_t  a_oreq;
    cbus_resp_t a_resp [MAXC];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [159:0] pq(input cbus_req_t r);
        logic [159:0] v;
        v = '0;
        v[$bits(cbus_req_t)-1:0] = r;
        return v;
    endfunction

    function automatic logic [159:0] pr(input cbus_resp_t r);
        logic [159:0] v;
        v = '0;
        v[$bits(cbus_resp_t)-1:0] = r;
        return v;
    endfunction

    function automatic cbus_req_t mk(input int d, input int i);
        cbus_req_t r;
        r          = '0;
        r.valid    = rv[d][i];
        r.is_write = rwr[d][i];
        r.size     = 3'd3;
        r.addr     = raddr[d][i];
        r.strobe   = rwr[d][i] ? 8'hff : 8'h00;
        r.data     = rdat[d][i];
        r.len      = 8'(rlen[d][i] - 1);
        return r;
    endfunction

    // Winner = first requesting channel scanning upward from the policy base.
    function automatic int pick(input int d);
        int base;
        base = rr[d] ? m_ptr[d] : 0;
        for (int k = 0; k < nch[d]; k++) begin
            if (rv[d][(base + k) % nch[d]]) return (base + k) % nch[d];
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < 4; i++) ireq0[i] = mk(0, i);
        for (int i = 0; i < 3; i++) ireq1[i] = mk(1, i);
        ireq2[0] = mk(2, 0);
        oresp0 = mresp[0];
        oresp1 = mresp[1];
        oresp2 = mresp[2];
    endtask

    task automatic sample(input int d);
        for (int j = 0; j < MAXC; j++) a_resp[j] = '0;
        case (d)
            0: begin
                a_busy = busy0; a_gid = int'(gid0); a_cnt = int'(cnt0); a_oreq = oreq0;
                for (int j = 0; j < 4; j++) a_resp[j] = iresp0[j];
            end
            1: begin
                a_busy = busy1; a_gid = int'(gid1); a_cnt = int'(cnt1); a_oreq = oreq1;
                for (int j = 0; j < 3; j++) a_resp[j] = iresp1[j];
            end
            default: begin
                a_busy = busy2; a_gid = int'(gid2); a_cnt = int'(cnt2); a_oreq = oreq2;
                a_resp[0] = iresp2[0];
            end
        endcase
    endtask

    task automatic check_all();
        cbus_req_t  eq;
        cbus_resp_t er;
        for (int d = 0; d < ND; d++) begin
            sample(d);
            check($sformatf("d%0d c%0d busy", d, cyc), 160'(a_busy), 160'(m_busy[d]));
            check($sformatf("d%0d c%0d grant_id", d, cyc), 160'(a_gid), 160'(m_gid[d]));
            check($sformatf("d%0d c%0d txn_count", d, cyc), 160'(a_cnt), 160'(m_cnt[d]));
            eq = m_busy[d] ? mk(d, m_gid[d]) : '0;
            check($sformatf("d%0d c%0d oreq", d, cyc), pq(a_oreq), pq(eq));
            for (int j = 0; j < nch[d]; j++) begin
                er = (m_busy[d] && j == m_gid[d]) ? mresp[d] : '0;
                check($sformatf("d%0d c%0d iresps%0d", d, cyc, j), pr(a_resp[j]), pr(er));
            end
        end
    endtask

    task automatic stimulus();
        for (int d = 0; d < ND; d++) begin
            if (drop[d] >= 0) begin
                rv[d][drop[d]] = 1'b0;
                drop[d] = -1;
            end
            for (int i = 0; i < nch[d]; i++) begin
                if (!rv[d][i] && (cyc == 0 || $urandom_range(0, 2) == 0)) begin
                    rv[d][i]    = 1'b1;
                    rlen[d][i]  = (cyc == 0) ? 1 : int'($urandom_range(1, 4));
                    raddr[d][i] = $urandom;
                    rdat[d][i]  = {$urandom, $urandom};
                    rwr[d][i]   = 1'($urandom_range(0, 1));
                end
            end
            mresp[d].data  = {$urandom, $urandom};
            mresp[d].ready = ($urandom_range(0, 3) != 0);
            if (m_busy[d] && mresp[d].ready)
                mresp[d].last = (m_beat[d] == rlen[d][m_gid[d]] - 1);
            else
                mresp[d].last = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_step();
        int w;
        for (int d = 0; d < ND; d++) begin
            if (m_busy[d]) begin
                if (mresp[d].ready && mresp[d].last) begin
                    m_busy[d] = 1'b0;
                    m_cnt[d]  = (m_cnt[d] + 1) & cmask[d];
                    if (rr[d]) m_ptr[d] = (m_gid[d] + 1) % nch[d];
                    drop[d] = m_gid[d];
                end else if (mresp[d].ready) begin
                    m_beat[d]++;
                end
            end else begin
                w = pick(d);
                if (w >= 0) begin
                    m_busy[d] = 1'b1;
                    m_gid[d]  = w;
                    m_beat[d] = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 1'b0;
            m_gid[d]  = 0;
            m_ptr[d]  = 0;
            m_cnt[d]  = 0;
            m_beat[d] = 0;
        end
    endtask

    initial begin
        model_reset();
        for (int d = 0; d < ND; d++) begin
            drop[d]  = -1;
            mresp[d] = '0;
            for (int i = 0; i < MAXC; i++) begin
                rv[d][i] = 1'b0; rlen[d][i] = 1; raddr[d][i] = '0; rdat[d][i] = '0; rwr[d][i] = 1'b0;
            end
        end
        reset = 1'b0;
        apply();
        repeat (2) @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        for (cyc = 0; cyc < NCYC; cyc++) begin
            stimulus();
            apply();
            #1;
            check_all();
            model_step();
            if (cyc == RST_CYC) begin
                #2;
                reset = 1'b0;
                #1;
                model_reset();
                check_all();
            end
            @(negedge clk);
            if (cyc == RST_CYC) reset = 1'b1;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
